// File: rtl/uart_transmitter_cp4.sv
//------------------------------------------------------------------------------
// Module  : uart_transmitter_cp4
// Brief   : 8N1 UART transmitter with a valid/ready byte handshake.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_transmitter_cp4 #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] C_BAUD_MAX =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                         r_state, w_state_next;
  logic [CLOCK_COUNTER_WIDTH-1:0] r_baud_cnt, w_baud_cnt_next;
  logic [2:0]                     r_bit_cnt, w_bit_cnt_next;
  // Start bit is driven directly; only data bits and the stop bit need storage.
  logic [8:0]                     r_shift, w_shift_next;
  logic                           r_serial, w_serial_next;
  logic                           r_ready, w_ready_next;
  logic                           w_fire;
  logic                           w_wrap;

  assign w_fire        = data_in_valid & r_ready;
  assign w_wrap        = (r_baud_cnt == C_BAUD_MAX);
  assign serial_out    = r_serial;
  assign data_in_ready = r_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_serial_next   = r_serial;
    w_ready_next    = r_ready;

    case (r_state)
      S_IDLE: begin
        w_baud_cnt_next = '0;
        w_bit_cnt_next  = 3'd0;
        w_serial_next   = 1'b1;
        w_ready_next    = 1'b1;
        if (w_fire) begin
          w_state_next  = S_START;
          w_shift_next  = {1'b1, data_in};
          w_serial_next = 1'b0;
          w_ready_next  = 1'b0;
        end
      end
      S_START: begin
        w_baud_cnt_next = w_wrap ? '0 : r_baud_cnt + 1'b1;
        if (w_wrap) begin
          w_state_next  = S_DATA;
          w_bit_cnt_next = 3'd0;
          w_serial_next = r_shift[0];
          w_shift_next  = {1'b1, r_shift[8:1]};
        end
      end
      S_DATA: begin
        w_baud_cnt_next = w_wrap ? '0 : r_baud_cnt + 1'b1;
        if (w_wrap) begin
          // After bit 7 the shifted-in stop bit (1) reaches r_shift[0].
          w_serial_next = r_shift[0];
          w_shift_next  = {1'b1, r_shift[8:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_next   = S_STOP;
            w_bit_cnt_next = 3'd0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
      end
      S_STOP: begin
        w_baud_cnt_next = w_wrap ? '0 : r_baud_cnt + 1'b1;
        if (w_wrap) begin
          w_state_next  = S_IDLE;
          w_serial_next = 1'b1;
          w_ready_next  = 1'b1;
        end
      end
      default: begin
        w_state_next    = S_IDLE;
        w_baud_cnt_next = '0;
        w_bit_cnt_next  = 3'd0;
        w_serial_next   = 1'b1;
        w_ready_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= '0;
      r_serial   <= 1'b1;
      r_ready    <= 1'b1;
    end else begin
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_serial   <= w_serial_next;
      r_ready    <= w_ready_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter_cp4.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_transmitter_cp4
// Brief   : Self-checking bench for uart_transmitter_cp4 against a line-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_transmitter_cp4;

  localparam int C_BIT_CYC = 10;

  logic       clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: the line value expected for each upcoming cycle; empty means idle.
  logic exp_q[$];
  logic exp_line;
  logic exp_ready;
  logic m_fire;
  logic prev_line;
  int   falls[$];

  uart_transmitter_cp4 #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_update();
    logic [9:0] frame;
    m_fire = reset_n && data_in_valid && (exp_q.size() == 0);
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_fire) begin
        frame = {1'b1, data_in, 1'b0};
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < C_BIT_CYC; j++)
            exp_q.push_back(frame[i]);
      end
    end
    exp_line  = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
    exp_ready = (exp_q.size() == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    check("serial_out", serial_out, exp_line);
    check("data_in_ready", data_in_ready, exp_ready);
    if (prev_line === 1'b1 && serial_out === 1'b0) falls.push_back(cyc);
    prev_line = serial_out;
  endtask

  task automatic wait_idle(input bit junk);
    int n;
    n = 0;
    while (data_in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (junk && data_in_ready !== 1'b1) begin
        data_in_valid = ($urandom_range(0, 2) == 0);
        data_in       = 8'($urandom);
      end
    end
    data_in_valid = 1'b0;
    check("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit junk);
    data_in       = b;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    data_in       = 8'($urandom);
    wait_idle(junk);
  endtask

  initial begin
    int low_cnt;
    reset_n       = 1'b0;
    data_in       = 8'h00;
    data_in_valid = 1'b0;
    prev_line     = 1'b1;
    exp_line      = 1'b1;
    exp_ready     = 1'b1;

    // Reset held, then released and idle
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();

    // Single byte A5, ready low for exactly one frame
    data_in       = 8'hA5;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    low_cnt = (data_in_ready === 1'b0) ? 1 : 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (data_in_ready === 1'b0) low_cnt++;
    end
    check("ready_low_cycles", 32'(low_cnt), 32'd100);

    // Back-to-back frames with valid held high
    falls.delete();
    data_in       = 8'h00;
    data_in_valid = 1'b1;
    tick();
    data_in = 8'hFF;
    begin
      int n;
      n = 0;
      m_fire = 1'b0;
      while (!m_fire && n < 200) begin
        tick();
        n++;
      end
      check("second_fire_seen", 32'(m_fire), 32'd1);
    end
    data_in_valid = 1'b0;
    wait_idle(1'b0);
    repeat (3) tick();
    check("falls_count", 32'(falls.size()), 32'd2);
    if (falls.size() >= 2) check("start_spacing", 32'(falls[1] - falls[0]), 32'd101);

    // Byte offered while busy is dropped
    data_in       = 8'h96;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    repeat (30) tick();
    data_in       = 8'h3C;
    data_in_valid = 1'b1;
    repeat (20) tick();
    data_in_valid = 1'b0;
    wait_idle(1'b0);
    repeat (15) tick();

    // data_in changes right after the handshake
    data_in       = 8'h55;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    data_in       = 8'hAA;
    wait_idle(1'b0);
    repeat (5) tick();

    // Reset during data bit 4, then a clean frame
    data_in       = 8'hEF;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    repeat (54) tick();
    check("pre_reset_bit4", 32'(serial_out), 32'd0);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("reset_line_async", 32'(serial_out), 32'd1);
    check("reset_ready_async", 32'(data_in_ready), 32'd1);
    prev_line = serial_out;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    send_byte(8'h81, 1'b0);
    repeat (5) tick();

    // Randomised traffic with idle gaps and ignored offers while busy
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 4)) tick();
      send_byte(8'($urandom), 1'b1);
    end
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
